// File: rtl/axi_arbiter_if.sv
// AXI4 bundle shared by the IFU/LSU masters and the xbar port; master drives requests, slave drives responses.
interface axi4_interface #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_arbiter.sv
// IFU/LSU -> xbar AXI4 arbiter, independent read/write grants held until rlast / B handshake.
// Zero-latency combinational routing in the grant cycle; losing master sees ready=0 until release.
module axi_arbiter #(
  parameter int LSU_PRIORITY = 1
) (
  input logic             clk,
  input logic             rst,
  axi4_interface.slave    ifu,
  axi4_interface.slave    lsu,
  axi4_interface.master   out
);
  localparam logic [1:0] R_IDLE = 2'd0, R_IFU = 2'd1, R_LSU = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_IFU = 2'd1, W_LSU = 2'd2;

  logic [1:0] rstate, wstate;
  logic       last_r, last_w;       // 1 = LSU was granted most recently
  logic       ar_done, aw_done, w_done;
  logic       rgnt, wgnt, r_sel, w_sel, r_act, w_act;
  logic       r_lsu, r_ifu, w_lsu, w_ifu;
  logic       r_release, w_release;

  function automatic logic pick(input logic req_ifu, input logic req_lsu, input logic last);
    if (req_ifu && req_lsu)
      return (LSU_PRIORITY != 0) ? 1'b1 : ~last;
    return req_lsu;
  endfunction

  always_comb begin
    rgnt  = pick(ifu.arvalid, lsu.arvalid, last_r);
    wgnt  = pick(ifu.awvalid, lsu.awvalid, last_w);
    r_act = (rstate != R_IDLE) | ifu.arvalid | lsu.arvalid;
    w_act = (wstate != W_IDLE) | ifu.awvalid | lsu.awvalid;
    r_sel = (rstate == R_IDLE) ? rgnt : (rstate == R_LSU);
    w_sel = (wstate == W_IDLE) ? wgnt : (wstate == W_LSU);
  end

  assign r_lsu = r_act & r_sel;
  assign r_ifu = r_act & ~r_sel;
  assign w_lsu = w_act & w_sel;
  assign w_ifu = w_act & ~w_sel;
  assign r_release = out.rvalid & out.rready & out.rlast;
  assign w_release = out.bvalid & out.bready;

  // Read request path
  assign out.arvalid = ~ar_done & ((r_lsu & lsu.arvalid) | (r_ifu & ifu.arvalid));
  assign out.araddr  = r_lsu ? lsu.araddr  : r_ifu ? ifu.araddr  : '0;
  assign out.arid    = r_lsu ? lsu.arid    : r_ifu ? ifu.arid    : '0;
  assign out.arlen   = r_lsu ? lsu.arlen   : r_ifu ? ifu.arlen   : '0;
  assign out.arsize  = r_lsu ? lsu.arsize  : r_ifu ? ifu.arsize  : '0;
  assign out.arburst = r_lsu ? lsu.arburst : r_ifu ? ifu.arburst : '0;
  assign out.rready  = (r_lsu & lsu.rready) | (r_ifu & ifu.rready);

  assign lsu.arready = r_lsu & ~ar_done & out.arready;
  assign ifu.arready = r_ifu & ~ar_done & out.arready;
  assign lsu.rvalid  = r_lsu & out.rvalid;
  assign ifu.rvalid  = r_ifu & out.rvalid;
  assign lsu.rlast   = r_lsu & out.rlast;
  assign ifu.rlast   = r_ifu & out.rlast;
  assign lsu.rdata   = r_lsu ? out.rdata : '0;
  assign ifu.rdata   = r_ifu ? out.rdata : '0;
  assign lsu.rresp   = r_lsu ? out.rresp : '0;
  assign ifu.rresp   = r_ifu ? out.rresp : '0;
  assign lsu.rid     = r_lsu ? out.rid   : '0;
  assign ifu.rid     = r_ifu ? out.rid   : '0;

  // Write request path
  assign out.awvalid = ~aw_done & ((w_lsu & lsu.awvalid) | (w_ifu & ifu.awvalid));
  assign out.wvalid  = ~w_done  & ((w_lsu & lsu.wvalid)  | (w_ifu & ifu.wvalid));
  assign out.awaddr  = w_lsu ? lsu.awaddr  : w_ifu ? ifu.awaddr  : '0;
  assign out.awid    = w_lsu ? lsu.awid    : w_ifu ? ifu.awid    : '0;
  assign out.awlen   = w_lsu ? lsu.awlen   : w_ifu ? ifu.awlen   : '0;
  assign out.awsize  = w_lsu ? lsu.awsize  : w_ifu ? ifu.awsize  : '0;
  assign out.awburst = w_lsu ? lsu.awburst : w_ifu ? ifu.awburst : '0;
  assign out.wdata   = w_lsu ? lsu.wdata   : w_ifu ? ifu.wdata   : '0;
  assign out.wstrb   = w_lsu ? lsu.wstrb   : w_ifu ? ifu.wstrb   : '0;
  assign out.wlast   = (w_lsu & lsu.wlast) | (w_ifu & ifu.wlast);
  assign out.bready  = (w_lsu & lsu.bready) | (w_ifu & ifu.bready);

  assign lsu.awready = w_lsu & ~aw_done & out.awready;
  assign ifu.awready = w_ifu & ~aw_done & out.awready;
  assign lsu.wready  = w_lsu & ~w_done & out.wready;
  assign ifu.wready  = w_ifu & ~w_done & out.wready;
  assign lsu.bvalid  = w_lsu & out.bvalid;
  assign ifu.bvalid  = w_ifu & out.bvalid;
  assign lsu.bresp   = w_lsu ? out.bresp : '0;
  assign ifu.bresp   = w_ifu ? out.bresp : '0;
  assign lsu.bid     = w_lsu ? out.bid   : '0;
  assign ifu.bid     = w_ifu ? out.bid   : '0;

  // Grant locks on first sight of arvalid since AXI forbids withdrawing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate  <= R_IDLE;
      ar_done <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      case (rstate)
        R_IDLE: if (ifu.arvalid | lsu.arvalid) begin
          rstate  <= rgnt ? R_LSU : R_IFU;
          last_r  <= rgnt;
          ar_done <= out.arvalid & out.arready;
        end
        R_IFU, R_LSU: if (r_release) begin
          rstate  <= R_IDLE;
          ar_done <= 1'b0;
        end else if (out.arvalid & out.arready) begin
          ar_done <= 1'b1;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // AW and W may complete in either order; both flags hold until the B handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate  <= W_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      last_w  <= 1'b1;
    end else begin
      case (wstate)
        W_IDLE: if (ifu.awvalid | lsu.awvalid) begin
          wstate  <= wgnt ? W_LSU : W_IFU;
          last_w  <= wgnt;
          aw_done <= out.awvalid & out.awready;
          w_done  <= out.wvalid & out.wready;
        end
        W_IFU, W_LSU: if (w_release) begin
          wstate  <= W_IDLE;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (out.awvalid & out.awready) aw_done <= 1'b1;
          if (out.wvalid & out.wready)   w_done  <= 1'b1;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end
endmodule

// File: doc/axi_arbiter.md
Name: axi_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter, placed between the core's memory masters (IFU, LSU) and the xbar.
- Read and write channels are arbitrated independently.
- Each grant is held from the first AR/AW valid until the transaction's last R beat or B handshake.
- Routing is combinational in the grant cycle, so an idle-path request reaches the xbar with zero added latency.

Parameters:
- LSU_PRIORITY, 1: 1 = fixed priority, LSU wins simultaneous requests. 0 = round-robin; the most recently granted master loses a tie.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ifu  axi4_interface.slave  -  instruction-fetch master; in practice reads only, but handled symmetrically
- lsu  axi4_interface.slave  -  load/store master
- out  axi4_interface.master  -  to xbar master port

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

- Read FSM, states R_IDLE, R_IFU, R_LSU:
  - R_IDLE arbitration: compute `rgnt` from ifu.arvalid and lsu.arvalid, using the priority rule and the `last_r` register.
  - Next state is R_IFU or R_LSU whenever any arvalid is seen, regardless of out.arready.
  - Grant is locked on first sight because AXI forbids withdrawing arvalid.
  - Release condition: R_IFU/R_LSU return to R_IDLE on out.rvalid & out.rready & out.rlast.
  - Next arbitration happens in the following cycle. Back-to-back transactions have no bubble beyond the R_IDLE arbitration cycle, which itself forwards AR.
- `ar_done` flag:
  - Set on out.arvalid & out.arready, in any state including R_IDLE.
  - Cleared on return to R_IDLE.
  - out.arvalid = granted.arvalid & ~ar_done.
- Read routing:
  - Granted master receives out.arready (gated by ~ar_done), rvalid, rdata, rresp, rlast, rid.
  - out.rready = granted.rready.
  - All AR fields (araddr, arid, arlen, arsize, arburst) pass through from the granted master.
  - Non-granted master: arready=0, rvalid=0, rdata=0, rresp=0, rlast=0, rid=0.
  - No grant (R_IDLE, no request): all out AR/R driven 0.
- `last_r`:
  - Updated to the granted master on R_IDLE exit.
  - Reset value LSU, so with LSU_PRIORITY=0 the first tie goes to IFU.

- Write FSM, states W_IDLE, W_IFU, W_LSU:
  - Same arbitration, triggered by awvalid.
  - Release on out.bvalid & out.bready.
- `aw_done` / `w_done` flags:
  - Set on their respective handshakes; cleared on release.
  - out.awvalid = g.awvalid & ~aw_done; out.wvalid = g.wvalid & ~w_done.
  - W may complete before AW; both orders are legal.
- Write routing:
  - AW/W fields (awaddr, awid, awlen, awsize, awburst, wdata, wstrb, wlast) pass through from the granted master.
  - B (bvalid, bresp, bid) is routed back only to the granted master.
  - Non-granted master and idle-state outputs are 0.
- Only single-beat writes are supported (awlen=0). Multi-beat reads are supported via rlast.
- Read and write FSMs are fully independent; e.g. an IFU read and an LSU write may be outstanding simultaneously.
- Simultaneous read-release and new request from the same master: release takes priority; the new request is arbitrated next cycle.

- Reset, including mid-transaction:
  - All FSMs go to idle; ar_done, aw_done, w_done cleared; last_r=LSU.
  - All outputs are 0 in the cycle after reset, with no requests pending.
  - Downstream slaves are reset in the same cycle.
  - In-flight responses are not carried over.

Test Plan:
- Single IFU read: ifu.araddr=0x3000_0000, arlen=0; slave arready at cycle 0, rvalid at cycle 2 with rdata=0xDEADBEEF -> out.arvalid in cycle 0; ifu sees rdata=0xDEADBEEF, rlast=1; FSM back to R_IDLE at cycle 3; lsu.rvalid=0 throughout.
- Contention, LSU_PRIORITY=1: ifu and lsu arvalid in the same cycle -> LSU granted, IFU arready=0 until LSU's rlast handshake; IFU served next cycle. With LSU_PRIORITY=0, two ties in a row -> IFU then LSU.
- Grant lock: LSU arvalid with out.arready held low 5 cycles, IFU arvalid rising in cycle 2 -> out.araddr stays LSU's for all cycles; no switch.
- Burst read: IFU arlen=3 -> 4 beats forwarded; grant held until the 4th beat (rlast); the LSU request pending meanwhile is granted the cycle after.
- Write ordering: LSU W (wdata=0x12345678, wstrb=0xF) handshaked 2 cycles before AW -> out.wvalid drops after the W handshake, AW forwarded once; bresp=OKAY returned to LSU; W_IDLE after the B handshake. Repeat with an IFU read overlapping -> both complete independently.
- Reset mid-read: rst asserted after the AR handshake, before rvalid -> next cycle all out valids 0 and FSMs idle; a fresh IFU read afterwards completes normally.
